// File: rtl/cnn_mac_pkg.sv
// Shared widths, legality limits and the output clamp helper for the CNN MAC engine.
// Default parameter set matches the 8s x 14s, 3x3-kernel configuration.
package cnn_mac_pkg;

  localparam int A_W_DEF       = 8;
  localparam int B_W_DEF       = 14;
  localparam int PROD_W        = A_W_DEF + B_W_DEF;
  localparam int MAX_W         = 64;
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;
  localparam int K_LEN_MIN     = 2;
  localparam int K_LEN_MAX     = 1024;

  function automatic int acc_w_min(input int a_w, input int b_w, input int k_len);
    return a_w + b_w + $clog2(k_len);
  endfunction

  typedef struct packed {
    logic                    ovf;
    logic signed [MAX_W-1:0] val;
  } sat_t;

  // Clamp a sign-extended value into the signed range of out_w bits.
  function automatic sat_t sat_to_width(input logic signed [MAX_W-1:0] v, input int out_w);
    sat_t                    r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi    = (MAX_W'(1) <<< (out_w - 1)) - MAX_W'(1);
    lo    = ~hi;
    r.ovf = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_mac_pipe_if.sv
// Operand/result handshake bundle between a pair source, the MAC engine and its consumer.
// slave is the engine side, master is the source/consumer side.
interface cnn_mac_pipe_if #(
  parameter int A_W   = 8,
  parameter int B_W   = 14,
  parameter int OUT_W = 22
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [A_W-1:0]   din0;
  logic signed [B_W-1:0]   din1;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] dout;
  logic                    ovf;

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, ovf
  );

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/cnn_mac_mul_pipe.sv
// Signed full-width multiplier with NUM_STAGE hold-able registers; stage 0 captures the product.
// Only valid bits are reset so the data path maps cleanly onto DSP pipeline registers.
module cnn_mac_mul_pipe #(
  parameter int A_W       = 8,
  parameter int B_W       = 14,
  parameter int NUM_STAGE = 3,
  localparam int P_W      = A_W + B_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  vld_i,
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  output logic                  vld_o,
  output logic signed [P_W-1:0] prod_o
);

  logic signed [P_W-1:0] a_x;
  logic signed [P_W-1:0] b_x;
  logic signed [P_W-1:0] prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  vld_q;

  assign a_x = P_W'(a_i);
  assign b_x = P_W'(b_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
    end else if (en_i) begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < NUM_STAGE; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      prod_q[0] <= a_x * b_x;
      for (int i = 1; i < NUM_STAGE; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  assign vld_o  = vld_q[NUM_STAGE-1];
  assign prod_o = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed MAC: sums K_LEN products per window, one result per window with full backpressure.
// CNN_MAC_SAT_EN selects saturating output with ovf; otherwise dout wraps and ovf stays 0.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W       = 8,
  parameter int B_W       = 14,
  parameter int NUM_STAGE = 3,
  parameter int K_LEN     = 9,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 22
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  cnn_mac_pipe_if.slave  io
);

  localparam int P_W = A_W + B_W;
  localparam int K_W = $clog2(K_LEN);

  if (ACC_W < acc_w_min(A_W, B_W, K_LEN) || ACC_W > MAX_W || OUT_W > ACC_W ||
      NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX ||
      K_LEN < K_LEN_MIN || K_LEN > K_LEN_MAX) begin : g_bad_params
    $error("cnn_mac_pipe: illegal parameter combination");
  end

  logic                    en;
  logic                    prod_vld;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    last;
  logic [OUT_W-1:0]        res_dout;
  logic                    res_ovf;

  logic [K_W-1:0]          k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        dout_q, dout_d;
  logic                    ovf_q, ovf_d;

  // A held result blocks the whole pipe, so every stage shares one enable.
  assign en          = !(out_valid_q && !io.out_ready);
  assign io.in_ready = en && ap_rst_n;

  cnn_mac_mul_pipe #(
    .A_W       (A_W),
    .B_W       (B_W),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .en_i   (en),
    .vld_i  (io.in_valid && io.in_ready),
    .a_i    (io.din0),
    .b_i    (io.din1),
    .vld_o  (prod_vld),
    .prod_o (prod)
  );

  assign prod_ext = ACC_W'(prod);
  assign sum      = (k_q == '0) ? prod_ext : acc_q + prod_ext;
  assign last     = (k_q == K_W'(K_LEN - 1));

`ifdef CNN_MAC_SAT_EN
  sat_t sat_res;
  always_comb begin
    sat_res  = sat_to_width(MAX_W'(sum), OUT_W);
    res_dout = sat_res.val[OUT_W-1:0];
    res_ovf  = sat_res.ovf;
  end
`else
  assign res_dout = sum[OUT_W-1:0];
  assign res_ovf  = 1'b0;
`endif

  always_comb begin
    k_d         = k_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (out_valid_q && io.out_ready) out_valid_d = 1'b0;
    if (en && prod_vld) begin
      if (last) begin
        k_d         = '0;
        out_valid_d = 1'b1;
        dout_d      = res_dout;
        ovf_d       = res_ovf;
      end else begin
        k_d   = k_q + K_W'(1);
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.dout      = dout_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Self-checking bench for cnn_mac_pipe: directed scenarios plus randomized traffic against a window-sum model.
module tb_cnn_mac_pipe;

  localparam int A_W       = 8;
  localparam int B_W       = 14;
  localparam int NUM_STAGE = 3;
  localparam int K_LEN     = 9;
  localparam int ACC_W     = 32;
  localparam int OUT_W     = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) ifc ();

  cnn_mac_pipe #(
    .A_W(A_W), .B_W(B_W), .NUM_STAGE(NUM_STAGE),
    .K_LEN(K_LEN), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .io       (ifc)
  );

  // Reference model: plain window sums, reduced mod 2^ACC_W, then clamped or wrapped to OUT_W.
  longint win_sum = 0;
  int     win_cnt = 0;
  int     last_acc_cyc = 0;
  int     exp_dout[$];
  bit     exp_ovf[$];
  int     obs_dout[$];
  bit     obs_ovf[$];
  int     obs_cyc[$];

  function automatic void model_result(input longint s, output int d, output bit o);
    logic signed [ACC_W-1:0] r;
    longint                  lim;
    logic signed [OUT_W-1:0] w;
    r   = s[ACC_W-1:0];
    lim = longint'(1) <<< (OUT_W - 1);
    w   = r[OUT_W-1:0];
`ifdef CNN_MAC_SAT_EN
    if (longint'(r) > lim - 1) begin
      d = int'(lim - 1); o = 1'b1;
    end else if (longint'(r) < -lim) begin
      d = int'(-lim); o = 1'b1;
    end else begin
      d = int'(r); o = 1'b0;
    end
`else
    d = int'(w);
    o = 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    int d;
    bit o;
    if (!rst_n) begin
      win_sum = 0;
      win_cnt = 0;
    end else begin
      if (ifc.in_valid && ifc.in_ready) begin
        win_sum += longint'(ifc.din0) * longint'(ifc.din1);
        win_cnt++;
        last_acc_cyc = cyc;
        if (win_cnt == K_LEN) begin
          model_result(win_sum, d, o);
          exp_dout.push_back(d);
          exp_ovf.push_back(o);
          win_sum = 0;
          win_cnt = 0;
        end
      end
      if (ifc.out_valid && ifc.out_ready) begin
        obs_dout.push_back(int'(ifc.dout));
        obs_ovf.push_back(ifc.ovf);
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_q();
    exp_dout.delete(); exp_ovf.delete();
    obs_dout.delete(); obs_ovf.delete(); obs_cyc.delete();
  endtask

  // Offer one pair and hold it until the engine takes it.
  task automatic send(input int a, input int b);
    int  t;
    bit  taken;
    t = 0;
    taken = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.din0 = A_W'(a);
    ifc.din1 = B_W'(b);
    while (!taken && t < 500) begin
      @(negedge clk);
      taken = ifc.in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!taken) begin
      checks++; failures++;
      $display("FAIL send_timeout: pair %0d,%0d not accepted within %0d cycles", a, b, t);
    end
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (obs_dout.size() < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (obs_dout.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", ifc.in_ready); end
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    checks++; if (ifc.dout !== '0) begin failures++; $display("FAIL reset_dout: got %0d want 0", ifc.dout); end
    checks++; if (ifc.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ifc.ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b want 1", ifc.in_ready); end
    clear_q();
  endtask

  task automatic test_ones();
    bit ok;
    clear_q();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < K_LEN; i++) send(1, 1);
    idle();
    wait_obs(1, 50, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL ones_timeout: got %0d results want 1", obs_dout.size());
    end else begin
      if (obs_dout[0] !== 9) begin failures++; $display("FAIL ones_dout: got %0d want 9", obs_dout[0]); end
      checks++; if (obs_ovf[0] !== 1'b0) begin failures++; $display("FAIL ones_ovf: got %b want 0", obs_ovf[0]); end
      checks++;
      if (obs_cyc[0] - last_acc_cyc !== NUM_STAGE + 1) begin
        failures++; $display("FAIL ones_latency: got %0d want %0d", obs_cyc[0] - last_acc_cyc, NUM_STAGE + 1);
      end
    end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (obs_dout.size() !== 1) begin failures++; $display("FAIL ones_pulse_count: got %0d want 1", obs_dout.size()); end
  endtask

  task automatic test_extreme();
    bit ok;
    int want_d;
    bit want_o;
`ifdef CNN_MAC_SAT_EN
    want_d = 2097151; want_o = 1'b1;
`else
    want_d = 1048576; want_o = 1'b0;
`endif
    clear_q();
    for (int i = 0; i < K_LEN; i++) send(-128, -8192);
    idle();
    wait_obs(1, 50, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL extreme_timeout: no result");
    end else begin
      if (obs_dout[0] !== want_d) begin failures++; $display("FAIL extreme_dout: got %0d want %0d", obs_dout[0], want_d); end
      checks++; if (obs_ovf[0] !== want_o) begin failures++; $display("FAIL extreme_ovf: got %b want %b", obs_ovf[0], want_o); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_q();
    for (int i = 0; i < K_LEN; i++) send(2, -3);
    for (int i = 0; i < K_LEN; i++) send(-1, 5);
    idle();
    wait_obs(2, 80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_timeout: got %0d results want 2", obs_dout.size());
    end else begin
      if (obs_dout[0] !== -54) begin failures++; $display("FAIL b2b_first: got %0d want -54", obs_dout[0]); end
      checks++; if (obs_dout[1] !== -45) begin failures++; $display("FAIL b2b_second: got %0d want -45", obs_dout[1]); end
      checks++; if (obs_cyc[1] - obs_cyc[0] !== K_LEN) begin failures++; $display("FAIL b2b_spacing: got %0d want %0d", obs_cyc[1] - obs_cyc[0], K_LEN); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_q();
    ifc.out_ready = 1'b0;
    for (int i = 0; i < K_LEN; i++) send(1, 2);
    idle();
    fork
      begin
        for (int i = 0; i < K_LEN; i++) send(3, 1);
        idle();
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid: got %b want 1", ifc.out_valid); end
        checks++; if (ifc.dout !== 18) begin failures++; $display("FAIL stall_dout_hold: got %0d want 18", ifc.dout); end
        checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b want 0", ifc.in_ready); end
        ifc.out_ready = 1'b1;
      end
    join
    wait_obs(2, 100, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL stall_timeout: got %0d results want 2", obs_dout.size());
    end else begin
      if (obs_dout[0] !== 18) begin failures++; $display("FAIL stall_first: got %0d want 18", obs_dout[0]); end
      checks++; if (obs_dout[1] !== 27) begin failures++; $display("FAIL stall_second: got %0d want 27", obs_dout[1]); end
    end
    repeat (15) @(posedge clk);
    #1;
    checks++; if (obs_dout.size() !== 2) begin failures++; $display("FAIL stall_count: got %0d want 2", obs_dout.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_q();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(1, 1);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b want 0", ifc.out_valid); end
    checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %b want 0", ifc.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < K_LEN; i++) send(1, 1);
    idle();
    wait_obs(1, 50, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL midrst_timeout: no result");
    end else if (obs_dout[0] !== 9) begin
      failures++; $display("FAIL midrst_dout: got %0d want 9", obs_dout[0]);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (obs_dout.size() !== 1) begin failures++; $display("FAIL midrst_count: got %0d want 1", obs_dout.size()); end
  endtask

  task automatic test_random();
    bit ok;
    bit done;
    int n;
    clear_q();
    done = 1'b0;
    fork
      begin
        for (int w = 0; w < 20; w++) begin
          for (int i = 0; i < K_LEN; i++) begin
            idle();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 16383)) - 8192);
          end
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ifc.out_ready = 1'($urandom_range(0, 1));
        end
        ifc.out_ready = 1'b1;
      end
    join
    wait_obs(20, 200, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (!ok || obs_dout.size() !== exp_dout.size()) begin
      failures++; $display("FAIL rand_count: got %0d results want %0d", obs_dout.size(), exp_dout.size());
    end
    n = (obs_dout.size() < exp_dout.size()) ? obs_dout.size() : exp_dout.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_dout[i] !== exp_dout[i] || obs_ovf[i] !== exp_ovf[i]) begin
        failures++;
        $display("FAIL rand_result[%0d]: got %0d/ovf %b want %0d/ovf %b", i, obs_dout[i], obs_ovf[i], exp_dout[i], exp_ovf[i]);
      end
    end
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.din0      = '0;
    ifc.din1      = '0;
    ifc.out_ready = 1'b1;
    test_reset();
    test_ones();
    test_extreme();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
